// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// frame width and divider sizing.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Width of the bit-period down-counter; wide enough to hold CLK_DIV-1.
    function automatic int div_w(input int clk_div);
        return $clog2(clk_div);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic [AW:0]      count_after_pop;
    logic             pop_ok;
    logic             push_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    assign rd_next         = rd_ptr + {{AW{1'b0}}, pop_ok};
    assign count_after_pop = count - {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    // Head register: a push into an (about to be) empty FIFO becomes the head
    // directly; otherwise the next unread slot is loaded. Holds when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (push_ok && count_after_pop == '0) begin
            data_out <= data_in;
        end else if (count_after_pop != '0) begin
            data_out <= mem[rd_next[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// receive FIFO presenting a valid/ready byte stream with sticky error flags.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 16
) (
    input  logic                     io_clock,
    input  logic                     io_reset,
    input  logic                     io_rxd,
    output logic                     io_rx_valid,
    output logic [7:0]               io_rx_payload,
    input  logic                     io_rx_ready,
    output logic [$clog2(DEPTH):0]   io_occupancy,
    output logic                     io_overflow,
    output logic                     io_frame_err,
    input  logic                     io_clear
);
    localparam int DW = div_w(CLK_DIV);

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_d;
    rx_state_t            state;
    logic [DW-1:0]        div;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 fall;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 ferr_set;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Synchronizer stages reset high so reset looks like an idle line.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= io_rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    assign tick     = (div == '0);
    assign fall     = rxd_d & ~rxd_s;
    assign push     = (state == STOP) & tick & rxd_s;
    assign ferr_set = (state == STOP) & tick & ~rxd_s;
    assign pop      = io_rx_valid & io_rx_ready;
    assign drop     = push & fifo_full & ~pop;

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Half a bit period lands the first sample mid start bit.
                    if (fall) begin
                        div   <= DW'(CLK_DIV / 2 - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            div     <= DW'(CLK_DIV - 1);
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        div <= div - DW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        div <= DW'(CLK_DIV - 1);
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        div <= div - DW'(1);
                    end
                end
                STOP: begin
                    if (tick) state <= rxd_s ? IDLE : WAIT_IDLE;
                    else      div   <= div - DW'(1);
                end
                WAIT_IDLE: begin
                    // A held-low line is one error, not a stream of frames.
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clock) begin
        if (state == DATA && tick) shift[bit_idx] <= rxd_s;
    end

    // A set event in the same cycle as io_clear wins.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            io_overflow  <= 1'b0;
            io_frame_err <= 1'b0;
        end else begin
            io_overflow  <= drop | (io_overflow & ~io_clear);
            io_frame_err <= ferr_set | (io_frame_err & ~io_clear);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (io_clock),
        .rst      (io_reset),
        .push     (push),
        .data_in  (shift),
        .full     (fifo_full),
        .pop      (pop),
        .data_out (io_rx_payload),
        .empty    (fifo_empty),
        .count    (io_occupancy)
    );

    assign io_rx_valid = ~fifo_empty;

endmodule
